// File: rtl/wed_status_writer_pkg.sv
// Shared types and helpers for the WED status write-back path: CAPI command and
// response codes, the WED_status record layout, the write-back FSM states, and
// the host-order packing function used when building the status cacheline.
package wed_status_writer_pkg;

  // CAPI command and response codes used by the write-back
  localparam logic [12:0] CAPI_CMD_WRITE_NA  = 13'h0D00;
  localparam logic [7:0]  CAPI_RSP_DONE      = 8'h00;
  localparam logic [7:0]  CAPI_RSP_FLUSHED   = 8'h06;
  localparam logic [7:0]  CAPI_RSP_PAGED     = 8'h0A;

  localparam int unsigned WB_LINE_W  = 1024;
  localparam int unsigned WB_FIELD_W = 64;
  localparam int unsigned WB_FIELDS  = 16;

  // Members are listed from the highest slot down so that done_flag lands in
  // bits [63:0] (slot 0), cycles_total in slot 2, and so on, matching the
  // field-k-at-bits-[64k+63:64k] layout of the data array.
  typedef struct packed {
    logic [63:0] pad15;
    logic [63:0] pad14;
    logic [63:0] pad13;
    logic [63:0] pad12;
    logic [63:0] pad11;
    logic [63:0] pad10;
    logic [63:0] pad9;
    logic [63:0] pad8;
    logic [63:0] pad7;
    logic [63:0] pad6;
    logic [63:0] writes;
    logic [63:0] reads;
    logic [63:0] tiles_done;
    logic [63:0] cycles_total;
    logic [63:0] error_code;
    logic [63:0] done_flag;
  } WED_status;

  typedef enum logic [2:0] {
    WB_RESET,
    WB_IDLE,
    WB_REQ,
    WB_WAIT_RESP,
    WB_DONE,
    WB_ERROR
  } wb_state;

  // Reverse the byte order of one 64-bit field
  function automatic logic [63:0] swap_endianness_double_word(input logic [63:0] d);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) begin
      r[8*b +: 8] = d[8*(7-b) +: 8];
    end
    return r;
  endfunction

  // Inverse of the fetch-side mapping: byte-swap each field into its line slot
  function automatic logic [WB_LINE_W-1:0] map_WED_status_to_DataArray(input WED_status s);
    logic [WB_LINE_W-1:0] flat;
    logic [WB_LINE_W-1:0] r;
    flat = s;
    for (int k = 0; k < WB_FIELDS; k++) begin
      r[WB_FIELD_W*k +: WB_FIELD_W] = swap_endianness_double_word(flat[WB_FIELD_W*k +: WB_FIELD_W]);
    end
    return r;
  endfunction

endpackage

// File: rtl/wed_status_writer.sv
// Writes the WED_status record back to host memory as one 128-byte line with a
// single write_na command, serves the PSL buffer reads for that line, and
// reissues the command on FLUSHED/PAGED responses up to MAX_RETRY times.
module wed_status_writer
  import wed_status_writer_pkg::*;
#(
  parameter logic [63:0] WB_OFFSET = 64'd128,
  parameter logic [7:0]  WB_TAG    = 8'hFE,
  parameter int unsigned MAX_RETRY = 4
) (
  input  logic           clock,
  input  logic           rstn,
  input  logic           enabled,
  input  logic [63:0]    wed_address,
  input  logic           status_valid,
  input  logic [1023:0]  status_in,
  input  logic           command_ready,
  output logic           command_valid,
  output logic [12:0]    command_code,
  output logic [63:0]    command_address,
  output logic [7:0]     command_tag,
  output logic [11:0]    command_size,
  input  logic           buffer_read_valid,
  input  logic [7:0]     buffer_read_tag,
  input  logic [5:0]     buffer_read_index,
  output logic [511:0]   buffer_read_data,
  input  logic           response_valid,
  input  logic [7:0]     response_tag,
  input  logic [7:0]     response_code,
  output logic           wb_busy,
  output logic           wb_done,
  output logic           wb_error,
  output logic           status_dropped
);

  // One extra count beyond MAX_RETRY is needed to detect exhaustion
  localparam int unsigned RW = $clog2(MAX_RETRY + 2);
  localparam logic [RW-1:0] MAX_RETRY_C = RW'(MAX_RETRY);

  wb_state         state_q;
  logic [RW-1:0]   retry_q;
  logic [RW-1:0]   retry_d;
  logic [1023:0]   line_q;
  WED_status       status_s;
  logic            rsp_hit;
  logic            capture;
  logic            unused_index;

  assign status_s     = status_in;
  assign retry_d      = retry_q + 1'b1;
  assign rsp_hit      = response_valid && (response_tag == WB_TAG);
  assign capture      = (state_q == WB_IDLE) && status_valid;
  // Only bit 0 of the index selects a half line
  assign unused_index = ^buffer_read_index[5:1];

  // Write-back FSM with registered command fields and status strobes
  always_ff @(posedge clock) begin
    if (!rstn) begin
      state_q         <= WB_RESET;
      retry_q         <= '0;
      command_valid   <= 1'b0;
      command_code    <= '0;
      command_address <= '0;
      command_tag     <= '0;
      command_size    <= '0;
      wb_busy         <= 1'b0;
      wb_done         <= 1'b0;
      wb_error        <= 1'b0;
      status_dropped  <= 1'b0;
    end else begin
      command_valid  <= 1'b0;
      wb_done        <= 1'b0;
      status_dropped <= status_valid && (state_q != WB_IDLE);
      case (state_q)
        WB_RESET: state_q <= WB_IDLE;
        WB_IDLE: begin
          if (status_valid) begin
            state_q <= WB_REQ;
            wb_busy <= 1'b1;
          end
        end
        WB_REQ: begin
          if (enabled && command_ready) begin
            command_valid   <= 1'b1;
            command_code    <= CAPI_CMD_WRITE_NA;
            command_address <= wed_address + WB_OFFSET;
            command_tag     <= WB_TAG;
            command_size    <= 12'd128;
            state_q         <= WB_WAIT_RESP;
          end
        end
        WB_WAIT_RESP: begin
          if (rsp_hit) begin
            case (response_code)
              CAPI_RSP_DONE: begin
                state_q <= WB_DONE;
                wb_done <= 1'b1;
              end
              CAPI_RSP_FLUSHED, CAPI_RSP_PAGED: begin
                retry_q <= retry_d;
                if (retry_d <= MAX_RETRY_C) begin
                  state_q <= WB_REQ;
                end else begin
                  state_q  <= WB_ERROR;
                  wb_error <= 1'b1;
                  wb_busy  <= 1'b0;
                end
              end
              default: begin
                state_q  <= WB_ERROR;
                wb_error <= 1'b1;
                wb_busy  <= 1'b0;
              end
            endcase
          end
        end
        WB_DONE: begin
          state_q <= WB_IDLE;
          wb_busy <= 1'b0;
          retry_q <= '0;
        end
        WB_ERROR: begin
          wb_error <= 1'b1;
          wb_busy  <= 1'b0;
        end
        default: state_q <= WB_RESET;
      endcase
    end
  end

  // Status line register, loaded only on an accepted capture
  always_ff @(posedge clock) begin
    if (!rstn) begin
      line_q <= '0;
    end else if (capture) begin
      line_q <= map_WED_status_to_DataArray(status_s);
    end
  end

  // Buffer-read mux: one-cycle latency, holds its value on foreign tags
  always_ff @(posedge clock) begin
    if (!rstn) begin
      buffer_read_data <= '0;
    end else if (buffer_read_valid && (buffer_read_tag == WB_TAG)) begin
      buffer_read_data <= buffer_read_index[0] ? line_q[1023:512] : line_q[511:0];
    end
  end

endmodule

// File: tb/tb_wed_status_writer.sv
// Directed bench for wed_status_writer: capture/command latency, byte-swapped
// line contents over buffer reads, retries, error exhaustion, drops and reset.
module tb_wed_status_writer;

  logic           clock = 1'b0;
  logic           rstn;
  logic           enabled;
  logic [63:0]    wed_address;
  logic           status_valid;
  logic [1023:0]  status_in;
  logic           command_ready;
  logic           command_valid;
  logic [12:0]    command_code;
  logic [63:0]    command_address;
  logic [7:0]     command_tag;
  logic [11:0]    command_size;
  logic           buffer_read_valid;
  logic [7:0]     buffer_read_tag;
  logic [5:0]     buffer_read_index;
  logic [511:0]   buffer_read_data;
  logic           response_valid;
  logic [7:0]     response_tag;
  logic [7:0]     response_code;
  logic           wb_busy;
  logic           wb_done;
  logic           wb_error;
  logic           status_dropped;

  int n_tests = 0;
  int n_fail  = 0;
  int cmd_cnt = 0;
  int snap;

  logic [511:0] exp_lo;
  logic [511:0] exp_hi;

  always #5 clock = ~clock;

  wed_status_writer dut (
    .clock            (clock),
    .rstn             (rstn),
    .enabled          (enabled),
    .wed_address      (wed_address),
    .status_valid     (status_valid),
    .status_in        (status_in),
    .command_ready    (command_ready),
    .command_valid    (command_valid),
    .command_code     (command_code),
    .command_address  (command_address),
    .command_tag      (command_tag),
    .command_size     (command_size),
    .buffer_read_valid(buffer_read_valid),
    .buffer_read_tag  (buffer_read_tag),
    .buffer_read_index(buffer_read_index),
    .buffer_read_data (buffer_read_data),
    .response_valid   (response_valid),
    .response_tag     (response_tag),
    .response_code    (response_code),
    .wb_busy          (wb_busy),
    .wb_done          (wb_done),
    .wb_error         (wb_error),
    .status_dropped   (status_dropped)
  );

  always @(negedge clock) begin
    if (command_valid === 1'b1) cmd_cnt++;
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One-cycle response strobe, sampled at the next edge
  task automatic respond(input logic [7:0] tag, input logic [7:0] code);
    response_valid = 1'b1;
    response_tag   = tag;
    response_code  = code;
    tick();
    response_valid = 1'b0;
  endtask

  task automatic bread(input logic [7:0] tag, input logic [5:0] idx);
    buffer_read_valid = 1'b1;
    buffer_read_tag   = tag;
    buffer_read_index = idx;
    tick();
    buffer_read_valid = 1'b0;
  endtask

  task automatic chk_cmd(input string tag);
    chk({tag, "_valid"}, 512'(command_valid), 512'(1'b1));
    chk({tag, "_addr"},  512'(command_address), 512'(64'h1080));
    chk({tag, "_tag"},   512'(command_tag), 512'(8'hFE));
    chk({tag, "_size"},  512'(command_size), 512'(12'd128));
    chk({tag, "_code"},  512'(command_code), 512'(13'h0D00));
  endtask

  initial begin
    rstn = 1'b0; enabled = 1'b1; wed_address = 64'h1000; status_valid = 1'b0;
    status_in = '0; command_ready = 1'b1; buffer_read_valid = 1'b0;
    buffer_read_tag = '0; buffer_read_index = '0; response_valid = 1'b0;
    response_tag = '0; response_code = '0;

    // status fields in host order, field k at bits [64k+63:64k]
    status_in[63:0]    = 64'h0000000000000001;
    status_in[191:128] = 64'h0102030405060708;
    status_in[383:320] = 64'hAABBCCDD11223344;
    status_in[639:576] = 64'h1122334455667788;
    exp_lo = '0;
    exp_lo[63:0]    = 64'h0100000000000000;
    exp_lo[191:128] = 64'h0807060504030201;
    exp_lo[383:320] = 64'h44332211DDCCBBAA;
    exp_hi = '0;
    exp_hi[127:64]  = 64'h8877665544332211;

    repeat (3) tick();
    chk("rst_cmd_valid", 512'(command_valid), 512'(1'b0));
    chk("rst_busy",      512'(wb_busy), 512'(1'b0));
    chk("rst_error",     512'(wb_error), 512'(1'b0));
    chk("rst_brdata",    buffer_read_data, '0);
    chk("rst_addr",      512'(command_address), 512'(64'h0));

    rstn = 1'b1;
    tick();                       // WB_RESET -> WB_IDLE
    status_valid = 1'b1;
    tick();                       // capture
    status_valid = 1'b0;
    chk("cap_busy",      512'(wb_busy), 512'(1'b1));
    chk("cap_cmd_early", 512'(command_valid), 512'(1'b0));
    tick();
    chk_cmd("cmd0");
    tick();
    chk("cmd0_one_cycle", 512'(command_valid), 512'(1'b0));

    // buffer reads
    bread(8'hFE, 6'd1);
    chk("bread_hi", buffer_read_data, exp_hi);
    bread(8'hFD, 6'd0);
    chk("bread_foreign_hold", buffer_read_data, exp_hi);
    bread(8'hFE, 6'd0);
    chk("bread_lo", buffer_read_data, exp_lo);

    // status while busy is dropped
    status_in = {1024{1'b1}};
    status_valid = 1'b1;
    tick();
    status_valid = 1'b0;
    chk("drop_pulse", 512'(status_dropped), 512'(1'b1));
    tick();
    chk("drop_one_cycle", 512'(status_dropped), 512'(1'b0));
    bread(8'hFE, 6'd0);
    chk("drop_line_kept", buffer_read_data, exp_lo);

    // foreign-tag response ignored
    respond(8'h11, 8'h00);
    chk("foreign_rsp_done", 512'(wb_done), 512'(1'b0));
    chk("foreign_rsp_busy", 512'(wb_busy), 512'(1'b1));

    // three PAGED, each gives an identical reissue
    snap = cmd_cnt;
    for (int i = 0; i < 3; i++) begin
      respond(8'hFE, 8'h0A);
      chk("retry_gap", 512'(command_valid), 512'(1'b0));
      tick();
      chk_cmd("retry_cmd");
      tick();
    end
    chk("retry_count", 512'(cmd_cnt - snap), 512'(3));

    // DONE, with a status strobe during WB_DONE that must be dropped
    respond(8'hFE, 8'h00);
    chk("done_pulse", 512'(wb_done), 512'(1'b1));
    chk("done_busy",  512'(wb_busy), 512'(1'b1));
    status_in = {16{64'h5555555555555555}};
    status_valid = 1'b1;
    tick();
    status_valid = 1'b0;
    chk("done_pulse_end", 512'(wb_done), 512'(1'b0));
    chk("done_busy_clr",  512'(wb_busy), 512'(1'b0));
    chk("done_drop",      512'(status_dropped), 512'(1'b1));
    snap = cmd_cnt;
    repeat (3) tick();
    chk("done_no_capture", 512'(wb_busy), 512'(1'b0));
    chk("done_no_cmd", 512'(cmd_cnt - snap), 512'(0));
    bread(8'hFE, 6'd0);
    chk("done_line_kept", buffer_read_data, exp_lo);

    // five PAGED exhaust the retry budget (counter must have been cleared)
    snap = cmd_cnt;
    status_in = '0;
    status_in[63:0] = 64'h2;
    status_valid = 1'b1;
    tick();
    status_valid = 1'b0;
    tick();
    chk("err_first_cmd", 512'(command_valid), 512'(1'b1));
    for (int i = 0; i < 5; i++) begin
      tick();
      respond(8'hFE, 8'h0A);
      tick();
    end
    repeat (4) tick();
    chk("err_flag",      512'(wb_error), 512'(1'b1));
    chk("err_busy",      512'(wb_busy), 512'(1'b0));
    chk("err_cmd_count", 512'(cmd_cnt - snap), 512'(5));
    respond(8'hFE, 8'h00);
    tick();
    chk("err_sticky", 512'(wb_error), 512'(1'b1));
    chk("err_no_done", 512'(wb_done), 512'(1'b0));
    bread(8'hFE, 6'd0);
    chk("err_line_new", 512'(buffer_read_data[63:0]), 512'(64'h0200000000000000));

    // reset clears the error
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("rst2_error", 512'(wb_error), 512'(1'b0));
    chk("rst2_brdata", buffer_read_data, '0);
    tick();

    // reset in WB_WAIT_RESP, then a late DONE in WB_IDLE
    status_valid = 1'b1;
    tick();
    status_valid = 1'b0;
    tick();
    chk_cmd("pre_rst_cmd");
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("mid_rst_busy", 512'(wb_busy), 512'(1'b0));
    tick();
    respond(8'hFE, 8'h00);
    chk("late_rsp_done", 512'(wb_done), 512'(1'b0));
    chk("late_rsp_busy", 512'(wb_busy), 512'(1'b0));
    tick();
    chk("late_rsp_done2", 512'(wb_done), 512'(1'b0));

    // capture works from WB_IDLE; enabled low holds the command back
    enabled = 1'b0;
    status_valid = 1'b1;
    tick();
    status_valid = 1'b0;
    chk("idle_capture", 512'(wb_busy), 512'(1'b1));
    tick();
    chk("disabled_no_cmd", 512'(command_valid), 512'(1'b0));
    tick();
    chk("disabled_no_cmd2", 512'(command_valid), 512'(1'b0));
    enabled = 1'b1;
    tick();
    chk_cmd("enabled_cmd");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
